// File: rtl/matrix_mult_ctrl.sv
// Matrix-side sequencer: C = A x B over the dual-port matrix memory, one A row, N B columns, one C row write per pass.
// Optional cycle counter output perf_cycles is enabled with `define MATRIX_MULT_CTRL_PERF_EN.
module matrix_mult_ctrl #(
  parameter int N       = 6,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1,
  parameter int ADDR    = 12
) (
  input  logic                 clk_MAT,
  input  logic                 rst_MAT,
  input  logic                 start,
  input  logic [ADDR-1:0]      A_base,
  input  logic [ADDR-1:0]      B_base,
  input  logic [ADDR-1:0]      C_base,
  output logic                 busy,
  output logic                 done,
  output logic                 A_MAT_rd,
  output logic [ADDR-1:0]      A_MAT_addr,
  input  logic [N*WIDTH-1:0]   A_MAT_dout,
  output logic                 B_MAT_rd,
  output logic [ADDR-1:0]      B_MAT_addr,
  input  logic [N*WIDTH-1:0]   B_MAT_dout,
  output logic                 C_MAT_wr,
  output logic [ADDR-1:0]      C_MAT_addr,
  output logic [N*M_WIDTH-1:0] C_MAT_din
`ifdef MATRIX_MULT_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, RD_A, WAIT_A, RD_B, FLUSH, WR_C, DONE} state_t;

  state_t                     state, state_nxt;
  logic [IW-1:0]              i_idx, j_idx, idx_p0;
  logic                       vld_p0;
  logic [ADDR-1:0]            a_base_q, b_base_q, c_base_q;
  logic [N*WIDTH-1:0]         a_row;
  logic [N*M_WIDTH-1:0]       c_row;
  logic signed [M_WIDTH-1:0]  sum_p1;

  function automatic logic signed [M_WIDTH-1:0] dot_lanes(input logic [N*WIDTH-1:0] a,
                                                          input logic [N*WIDTH-1:0] b);
    logic signed [M_WIDTH-1:0] acc;
    logic signed [WIDTH-1:0]   ak, bk;
    logic signed [2*WIDTH-1:0] prod;
    acc = '0;
    for (int k = 0; k < N; k++) begin
      ak   = a[k*WIDTH +: WIDTH];
      bk   = b[k*WIDTH +: WIDTH];
      prod = ak * bk;
      acc  = acc + M_WIDTH'(prod);
    end
    return acc;
  endfunction

  always_ff @(posedge clk_MAT) begin
    if (rst_MAT) begin
      state  <= IDLE;
      i_idx  <= '0;
      j_idx  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= (state == RD_B);
      case (state)
        IDLE:    if (start) i_idx <= '0;
        WAIT_A:  j_idx <= '0;
        RD_B:    j_idx <= j_idx + 1'b1;
        WR_C:    if (i_idx != IW'(N-1)) i_idx <= i_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // p0: B read issued with column index; p1: B data returns, lane products summed into c_row
  assign sum_p1 = dot_lanes(a_row, B_MAT_dout);

  always_ff @(posedge clk_MAT) begin
    idx_p0 <= j_idx;
    if (state == IDLE && start) begin
      a_base_q <= A_base;
      b_base_q <= B_base;
      c_base_q <= C_base;
    end
    if (rst_MAT) begin
      a_row <= '0;
      c_row <= '0;
    end else begin
      if (state == WAIT_A) a_row <= A_MAT_dout;
      for (int c = 0; c < N; c++)
        if (vld_p0 && idx_p0 == IW'(c)) c_row[c*M_WIDTH +: M_WIDTH] <= sum_p1;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    A_MAT_rd   = 1'b0;
    A_MAT_addr = '0;
    B_MAT_rd   = 1'b0;
    B_MAT_addr = '0;
    C_MAT_wr   = 1'b0;
    C_MAT_addr = '0;
    C_MAT_din  = '0;
    case (state)
      IDLE:   if (start) state_nxt = RD_A;
      RD_A: begin
        A_MAT_rd   = 1'b1;
        A_MAT_addr = a_base_q + ADDR'(i_idx);
        state_nxt  = WAIT_A;
      end
      WAIT_A: state_nxt = RD_B;
      RD_B: begin
        B_MAT_rd   = 1'b1;
        B_MAT_addr = b_base_q + ADDR'(j_idx);
        if (j_idx == IW'(N-1)) state_nxt = FLUSH;
      end
      FLUSH:  state_nxt = WR_C;
      WR_C: begin
        C_MAT_wr   = 1'b1;
        C_MAT_addr = c_base_q + ADDR'(i_idx);
        C_MAT_din  = c_row;
        state_nxt  = (i_idx == IW'(N-1)) ? DONE : RD_A;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MATRIX_MULT_CTRL_PERF_EN
  always_ff @(posedge clk_MAT) begin
    if (rst_MAT)
      perf_cycles <= '0;
    else if (state == IDLE) begin
      if (start) perf_cycles <= '0;
    end else if (perf_cycles != 32'hFFFF_FFFF)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/matrix_mult_ctrl.md
Name: matrix_mult_ctrl

Overview:
- Sequencer for the matrix side of the dual-port matrix memory (clk_MAT domain).
- On start, computes C = A x B for an N x N signed matrix:
  - reads one A row, then streams the N B columns;
  - forms each dot product in an internal N-lane multiply/adder tree;
  - writes each completed C row back.
- Drives the memory's A_MAT/B_MAT read ports and C_MAT write port directly.
- Exposes a start/busy/done handshake to the user-side control.

Parameters:
- N, 6, matrix dimension; elements per memory word.
- WIDTH, 16, signed A/B element width.
- M_WIDTH, 2*WIDTH+N-1, signed C element width.
- ADDR, 12, memory address width.

Ports:
- clk_MAT  in  1  matrix clock; all logic on rising edge.
- rst_MAT  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- A_base  in  ADDR  address of A row 0; latched on accepted start.
- B_base  in  ADDR  address of B column 0; latched on accepted start.
- C_base  in  ADDR  address of C row 0; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final C row is written.
- A_MAT_rd  out  1  A read enable.
- A_MAT_addr  out  ADDR  A read address.
- A_MAT_dout  in  N*WIDTH  A row data; valid the cycle after A_MAT_rd.
- B_MAT_rd  out  1  B read enable.
- B_MAT_addr  out  ADDR  B read address.
- B_MAT_dout  in  N*WIDTH  B column data; valid the cycle after B_MAT_rd.
- C_MAT_wr  out  1  C write enable.
- C_MAT_addr  out  ADDR  C write address.
- C_MAT_din  out  N*M_WIDTH  C row data.

Behaviour:
- Single clock, clk_MAT. Reset rst_MAT is synchronous and active-high.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - row index i = 0, column index j = 0;
  - a_row and c_row registers cleared.
- Memory layout:
  - A row r at A_base+r; B column c at B_base+c; C row r at C_base+r.
  - A/B element k at bits [k*WIDTH +: WIDTH]; C element c at bits [c*M_WIDTH +: M_WIDTH].
  - Address sums wrap modulo 2^ADDR.
- States and transitions:
  - IDLE: start=1 -> latch bases, i=0 -> RD_A. Otherwise stay.
  - RD_A (1 cycle): A_MAT_rd=1, A_MAT_addr=A_base+i -> WAIT_A.
  - WAIT_A (1 cycle): at cycle end, a_row <= A_MAT_dout; j=0 -> RD_B.
  - RD_B (N cycles): B_MAT_rd=1, B_MAT_addr=B_base+j, j increments each cycle.
    - The B data arriving in the following cycle is multiplied lane-wise (signed) with a_row.
    - The N products are sign-extended to M_WIDTH, summed, and registered into c_row[j-1] at that cycle's end.
    - After j=N-1 -> FLUSH.
  - FLUSH (1 cycle): c_row[N-1] registered -> WR_C.
  - WR_C (1 cycle): C_MAT_wr=1, C_MAT_addr=C_base+i, C_MAT_din=c_row.
    - If i=N-1 -> DONE; else i++ -> RD_A.
  - DONE (1 cycle): done=1 -> IDLE.
- Timing:
  - Per row: N+4 cycles.
  - done is asserted exactly N*(N+4)+1 cycles after the edge that sampled start.
- Outside their active states, rd/wr strobes are 0. Addresses and C_MAT_din are don't-care when their strobe is 0.
- start while busy is ignored and does not queue. start in the same cycle as the DONE pulse is also ignored; it is accepted only once IDLE is re-entered.
- Arithmetic:
  - Full-precision signed accumulation; no overflow is possible for the default M_WIDTH.
  - Result is the exact two's-complement sum.
- rst_MAT asserted mid-operation:
  - next cycle is IDLE, all strobes 0, busy=0, done=0;
  - partially written C contents are left as is; no further writes occur.

Optional Feature:
- Macro: MATRIX_MULT_CTRL_PERF_EN.
- When defined:
  - adds output perf_cycles [31:0];
  - it is cleared on accepted start, increments every cycle busy=1, and holds its value in IDLE;
  - it saturates at 32'hFFFFFFFF;
  - reset value 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- N=2, WIDTH=8; A rows (1,2),(3,4); B columns (5,7),(6,8); bases 0,0x10,0x20:
  - -> C row 0x20 = (19,22), row 0x21 = (43,50);
  - done pulses exactly 13 cycles after start; busy high for cycles 1..13.
- Defaults (N=6, WIDTH=16); all A and B elements = -32768:
  - -> every C element = 6442450944 (signed, 37-bit); 6 C writes, one per row.
- A_base = 2^ADDR-1, N=2:
  - -> second A read address = 0 (wrap); C results correct.
- start pulsed in cycles 3 and at the DONE cycle:
  - -> no restart, single done pulse;
  - start one cycle after DONE -> new run accepted.
- rst_MAT asserted during RD_B of row 1:
  - -> next cycle IDLE, busy=0, no further C_MAT_wr, done never pulses;
  - subsequent start completes a correct full run.
- With MATRIX_MULT_CTRL_PERF_EN, N=2 run:
  - -> perf_cycles = 13 after done and holds in IDLE.
